output_display_driver: RTL and testbench

//   Consumes the 8-bit display_output of the SAP-1 Output Register and drives a
//   3-digit multiplexed common-anode 7-segment display with its unsigned decimal value.

---
 rtl/output_display_driver.sv | 150 +++++++++++++++
 tb/tb_output_display_driver.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/output_display_driver.sv
// Binary-to-decimal display driver: sequential double-dabble conversion feeding a
// 3-digit multiplexed common-anode 7-segment display with optional leading-zero blanking.
module output_display_driver #(
  parameter int REFRESH_DIV   = 4,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic [7:0] display_input,
  output logic [6:0] seg_bar,
  output logic [2:0] dig_bar,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

  localparam logic [15:0] REFRESH_LAST = 16'(REFRESH_DIV - 1);
  localparam logic [6:0]  SEG_BLANK    = 7'h7F;

  state_t      state, state_next;
  logic [7:0]  last_value, last_next;
  logic [19:0] shift_reg, shift_next;
  logic [2:0]  iter, iter_next;
  logic [3:0]  hund, tens, units;
  logic [3:0]  hund_next, tens_next, units_next;
  logic [15:0] refresh_cnt, refresh_next;
  logic [1:0]  scan_idx, scan_next;
  logic [6:0]  seg_next;
  logic [2:0]  dig_next;

  // One double-dabble iteration: correct each BCD nibble, then shift left.
  function automatic logic [19:0] dabble_step(input logic [19:0] s);
    logic [19:0] a;
    a = s;
    for (int i = 0; i < 3; i++) begin
      if (a[8+4*i +: 4] >= 4'd5) a[8+4*i +: 4] = a[8+4*i +: 4] + 4'd3;
    end
    return {a[18:0], 1'b0};
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return SEG_BLANK;
    endcase
  endfunction

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (CLR) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every signal gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_next = state;
    last_next  = last_value;
    shift_next = shift_reg;
    iter_next  = iter;
    hund_next  = hund;
    tens_next  = tens;
    units_next = units;
    case (state)
      IDLE: begin
        if (display_input != last_value) begin
          last_next  = display_input;
          shift_next = {12'b0, display_input};
          iter_next  = 3'd0;
          state_next = CONVERT;
        end
      end
      CONVERT: begin
        shift_next = dabble_step(shift_reg);
        iter_next  = iter + 3'd1;
        if (iter == 3'd7) state_next = COMMIT;
      end
      COMMIT: begin
        hund_next  = shift_reg[19:16];
        tens_next  = shift_reg[15:12];
        units_next = shift_reg[11:8];
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from next-state values so seg/dig pairs land on the same edge
  // as the scan step and as a digit commit.
  always_comb begin
    refresh_next = refresh_cnt + 16'd1;
    scan_next    = scan_idx;
    if (refresh_cnt >= REFRESH_LAST) begin
      refresh_next = 16'd0;
      scan_next    = (scan_idx == 2'd2) ? 2'd0 : scan_idx + 2'd1;
    end
    case (scan_next)
      2'd0: begin
        dig_next = 3'b110;
        seg_next = seg_decode(units_next);
      end
      2'd1: begin
        dig_next = 3'b101;
        seg_next = (BLANK_LEADING && hund_next == 4'd0 && tens_next == 4'd0)
                   ? SEG_BLANK : seg_decode(tens_next);
      end
      default: begin
        dig_next = 3'b011;
        seg_next = (BLANK_LEADING && hund_next == 4'd0) ? SEG_BLANK : seg_decode(hund_next);
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      last_value  <= 8'd0;
      shift_reg   <= 20'd0;
      iter        <= 3'd0;
      hund        <= 4'd0;
      tens        <= 4'd0;
      units       <= 4'd0;
      refresh_cnt <= 16'd0;
      scan_idx    <= 2'd0;
      seg_bar     <= 7'h40;
      dig_bar     <= 3'b110;
    end else begin
      last_value  <= last_next;
      shift_reg   <= shift_next;
      iter        <= iter_next;
      hund        <= hund_next;
      tens        <= tens_next;
      units       <= units_next;
      refresh_cnt <= refresh_next;
      scan_idx    <= scan_next;
      seg_bar     <= seg_next;
      dig_bar     <= dig_next;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_output_display_driver.sv
// Scoreboard bench for output_display_driver: one blanking and one non-blanking instance
// share stimulus; expected values queue on drive and are checked when busy falls.
module tb_output_display_driver;

  logic       CLK = 1'b0;
  logic       CLR;
  logic [7:0] display_input;
  logic [6:0] seg_bar, seg_bar_nb;
  logic [2:0] dig_bar, dig_bar_nb;
  logic       busy, busy_nb;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  always #5 CLK = ~CLK;

  output_display_driver #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) dut (
    .CLK(CLK), .CLR(CLR), .display_input(display_input),
    .seg_bar(seg_bar), .dig_bar(dig_bar), .busy(busy)
  );

  output_display_driver #(.REFRESH_DIV(4), .BLANK_LEADING(1'b0)) dut_nb (
    .CLK(CLK), .CLR(CLR), .display_input(display_input),
    .seg_bar(seg_bar_nb), .dig_bar(dig_bar_nb), .busy(busy_nb)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [6:0] seg_model(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int value, input int pos, input bit blank);
    int h, t, u;
    h = value / 100;
    t = (value / 10) % 10;
    u = value % 10;
    if (pos == 0) return seg_model(u);
    if (pos == 1) return (blank && h == 0 && t == 0) ? 7'h7F : seg_model(t);
    return (blank && h == 0) ? 7'h7F : seg_model(h);
  endfunction

  // Walk the scan until each digit is selected and compare both instances.
  task automatic check_display(input string tag, input int value);
    for (int pos = 0; pos < 3; pos++) begin
      logic [2:0] pat;
      int n;
      pat = 3'b111 ^ (3'b001 << pos);
      n = 0;
      while (dig_bar !== pat && n < 16) begin
        tick();
        n++;
      end
      check($sformatf("%s_dig%0d", tag, pos), 32'(dig_bar), 32'(pat));
      check($sformatf("%s_seg%0d", tag, pos), 32'(seg_bar), 32'(exp_seg(value, pos, 1'b1)));
      check($sformatf("%s_nbdig%0d", tag, pos), 32'(dig_bar_nb), 32'(pat));
      check($sformatf("%s_nbseg%0d", tag, pos), 32'(seg_bar_nb), 32'(exp_seg(value, pos, 1'b0)));
    end
  endtask

  // Tick until busy falls; pop the expected value and check the digit visible right then.
  task automatic wait_commit(input string tag, input int exp_edges, input bit full);
    int n, value, pos;
    tick();
    n = 1;
    check({tag, "_busy_start"}, 32'(busy), 32'd1);
    while (busy && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
    check({tag, "_nbbusy_done"}, 32'(busy_nb), 32'd0);
    if (exp_edges > 0) check({tag, "_latency"}, 32'(n), 32'(exp_edges));
    check({tag, "_queue"}, 32'(exp_q.size() > 0), 32'd1);
    value = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
    pos = (dig_bar == 3'b110) ? 0 : (dig_bar == 3'b101) ? 1 : (dig_bar == 3'b011) ? 2 : -1;
    if (pos < 0) begin
      check({tag, "_onehot"}, 32'(dig_bar), 32'b110);
    end else begin
      check({tag, "_commit_seg"}, 32'(seg_bar), 32'(exp_seg(value, pos, 1'b1)));
      check({tag, "_commit_nbseg"}, 32'(seg_bar_nb), 32'(exp_seg(value, pos, 1'b0)));
    end
    if (full) check_display(tag, value);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vals[4];
    vals = '{255, 100, 10, 9};
    CLR = 1'b1;
    display_input = 8'h00;

    // Reset and refresh scan timing: each digit held 4 cycles, leading digits blank.
    tick();
    tick();
    CLR = 1'b0;
    check("rst_dig", 32'(dig_bar), 32'b110);
    check("rst_seg", 32'(seg_bar), 32'h40);
    check("rst_busy", 32'(busy), 32'd0);
    for (int k = 1; k <= 12; k++) begin
      int idx;
      tick();
      idx = (k / 4) % 3;
      check($sformatf("scan%0d_dig", k), 32'(dig_bar), 32'(3'b111 ^ (3'b001 << idx)));
      check($sformatf("scan%0d_seg", k), 32'(seg_bar), 32'((idx == 0) ? 7'h40 : 7'h7F));
      check($sformatf("scan%0d_nbseg", k), 32'(seg_bar_nb), 32'h40);
    end

    // Single conversion with exact latency.
    display_input = 8'h32;
    exp_q.push_back(50);
    wait_commit("v50", 10, 1'b1);

    foreach (vals[i]) begin
      display_input = 8'(vals[i]);
      exp_q.push_back(vals[i]);
      wait_commit($sformatf("v%0d", vals[i]), 10, 1'b1);
    end

    // Input change during conversion is deferred to the next IDLE edge.
    display_input = 8'h32;
    exp_q.push_back(50);
    tick();
    check("t4_e0_busy", 32'(busy), 32'd1);
    tick();
    tick();
    display_input = 8'hD8;
    exp_q.push_back(216);
    wait_commit("t4a", 7, 1'b0);
    wait_commit("t4b", 10, 1'b1);

    // Small value: blanking vs full display, then scan wraps back to units.
    display_input = 8'h07;
    exp_q.push_back(7);
    wait_commit("t5", 10, 1'b1);
    begin
      int n;
      n = 0;
      while (dig_bar !== 3'b110 && n < 16) begin
        tick();
        n++;
      end
      check("t5_wrap_dig", 32'(dig_bar), 32'b110);
      check("t5_wrap_nbseg", 32'(seg_bar_nb), 32'h78);
    end

    // Reset mid-conversion aborts; the held input restarts right after.
    display_input = 8'h32;
    tick();
    tick();
    tick();
    tick();
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_dig", 32'(dig_bar), 32'b110);
    check("t6_seg", 32'(seg_bar), 32'h40);
    check("t6_nbseg", 32'(seg_bar_nb), 32'h40);
    exp_q.push_back(50);
    wait_commit("t6", 10, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
